ps2_host_tx: RTL and testbench



---
 rtl/ps2_host_tx_pkg.sv | 32 +++
 rtl/ps2_line_filter.sv | 52 +++++
 rtl/ps2_host_tx.sv | 148 ++++++++++++++
 tb/tb_ps2_host_tx.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_host_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ps2_host_tx_pkg
// Brief   : Shared PS/2 timing defaults, host-transmit state encodings, parity.
// Revision: 1.0 - initial release
// ============================================================================
package ps2_host_tx_pkg;

  localparam int unsigned c_inhibit_cycles = 12000;
  localparam int unsigned c_timeout_cycles = 2000000;
  localparam int unsigned c_filter_len     = 8;

  localparam int unsigned c_state_w = 4;
  typedef logic [c_state_w-1:0] state_t;

  localparam state_t c_st_idle    = 4'd0;
  localparam state_t c_st_inhibit = 4'd1;
  localparam state_t c_st_request = 4'd2;
  localparam state_t c_st_data    = 4'd3;
  localparam state_t c_st_parity  = 4'd4;
  localparam state_t c_st_stop    = 4'd5;
  localparam state_t c_st_ack     = 4'd6;
  localparam state_t c_st_release = 4'd7;
  localparam state_t c_st_finish  = 4'd8;

  // PS/2 uses odd parity: the bit makes the total count of ones odd.
  function automatic logic odd_parity_bit(input logic [7:0] b);
    return ~(^b);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// ============================================================================
// Module  : ps2_line_filter
// Brief   : 2-flop synchronizer, FILTER_LEN glitch filter, falling-edge pulse.
// Revision: 1.0 - initial release
// ============================================================================
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic level,
  output logic fall
);

  localparam int unsigned c_cnt_w = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FILTER_LEN - 1);

  logic [1:0]         r_sync;
  logic               r_level;
  logic               r_fall;
  logic [c_cnt_w-1:0] r_cnt;

  // A new level is accepted only after FILTER_LEN consecutive samples disagree
  // with the current one; any sample that agrees restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync  <= 2'b11;
      r_level <= 1'b1;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync <= {r_sync[0], line_in};
      r_fall <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_level <= r_sync[1];
        r_fall  <= ~r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
    end
  end

  assign level = r_level;
  assign fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module  : ps2_host_tx
// Brief   : PS/2 host-to-device command transmitter with ACK check and timeout.
// Revision: 1.0 - initial release
// ============================================================================
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = c_inhibit_cycles,
  parameter int unsigned TIMEOUT_CYCLES = c_timeout_cycles,
  parameter int unsigned FILTER_LEN     = c_filter_len
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned c_inh_w = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int unsigned c_tmo_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_inh_w-1:0] c_inh_last = c_inh_w'(INHIBIT_CYCLES - 1);
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [7:0]         r_data;
  logic [c_inh_w-1:0] r_inh_cnt;
  logic [c_tmo_w-1:0] r_tmo_cnt;
  logic [2:0]         r_bit_cnt;
  logic               r_ack;
  logic               r_ps2c_oe;
  logic               r_ps2d_oe;
  logic               w_ps2c_oe_nxt;
  logic               w_ps2d_oe_nxt;
  logic               w_c_level;
  logic               w_c_fall;
  logic               w_d_level;
  logic               w_in_frame;
  logic               w_timeout;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk    (clk),
    .rst    (rst),
    .line_in(ps2c_in),
    .level  (w_c_level),
    .fall   (w_c_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk    (clk),
    .rst    (rst),
    .line_in(ps2d_in),
    .level  (w_d_level),
    .fall   ()
  );

  assign w_in_frame = r_state inside {c_st_request, c_st_data, c_st_parity,
                                      c_st_stop, c_st_ack, c_st_release};
  assign w_timeout  = w_in_frame && !w_c_fall && (r_tmo_cnt == c_tmo_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= c_st_idle;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:    if (tx_start) w_state_nxt = c_st_inhibit;
      c_st_inhibit: if (r_inh_cnt == c_inh_last) w_state_nxt = c_st_request;
      c_st_request: w_state_nxt = c_st_data;
      c_st_data:    if (w_c_fall && (r_bit_cnt == 3'd7)) w_state_nxt = c_st_parity;
      c_st_parity:  if (w_c_fall) w_state_nxt = c_st_stop;
      c_st_stop:    if (w_c_fall) w_state_nxt = c_st_ack;
      c_st_ack:     if (w_c_fall) w_state_nxt = c_st_release;
      c_st_release: if (w_c_level && w_d_level) w_state_nxt = c_st_finish;
      c_st_finish:  w_state_nxt = c_st_idle;
      default:      w_state_nxt = c_st_idle;
    endcase
    // A stalled device aborts the frame through FINISH, which reports err.
    if (w_timeout) w_state_nxt = c_st_finish;
  end

  // Pad enables are computed for the state being entered and then registered.
  always_comb begin
    w_ps2c_oe_nxt = (w_state_nxt == c_st_inhibit) || (w_state_nxt == c_st_request);
    w_ps2d_oe_nxt = r_ps2d_oe;
    if (w_c_fall) begin
      case (r_state)
        c_st_data:   w_ps2d_oe_nxt = ~r_data[r_bit_cnt];
        c_st_parity: w_ps2d_oe_nxt = ~odd_parity_bit(r_data);
        c_st_stop:   w_ps2d_oe_nxt = 1'b0;
        default:     w_ps2d_oe_nxt = r_ps2d_oe;
      endcase
    end
    if (w_state_nxt == c_st_request) begin
      w_ps2d_oe_nxt = 1'b1;
    end else if (w_state_nxt inside {c_st_idle, c_st_inhibit, c_st_finish}) begin
      w_ps2d_oe_nxt = 1'b0;
    end
    busy = (r_state != c_st_idle);
    done = (r_state == c_st_finish) &&  r_ack;
    err  = (r_state == c_st_finish) && !r_ack;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data    <= '0;
      r_inh_cnt <= '0;
      r_tmo_cnt <= '0;
      r_bit_cnt <= '0;
      r_ack     <= 1'b0;
      r_ps2c_oe <= 1'b0;
      r_ps2d_oe <= 1'b0;
    end else begin
      r_ps2c_oe <= w_ps2c_oe_nxt;
      r_ps2d_oe <= w_ps2d_oe_nxt;

      if ((r_state == c_st_idle) && tx_start) r_data <= tx_data;

      if (r_state == c_st_inhibit) r_inh_cnt <= r_inh_cnt + c_inh_w'(1);
      else                         r_inh_cnt <= '0;

      if (w_in_frame && !w_c_fall) r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
      else                         r_tmo_cnt <= '0;

      if (r_state != c_st_data)  r_bit_cnt <= '0;
      else if (w_c_fall)         r_bit_cnt <= r_bit_cnt + 3'd1;

      if (r_state == c_st_idle)              r_ack <= 1'b0;
      else if (w_timeout)                    r_ack <= 1'b0;
      else if ((r_state == c_st_ack) && w_c_fall) r_ack <= ~w_d_level;
    end
  end

  assign ps2c_oe = r_ps2c_oe;
  assign ps2d_oe = r_ps2d_oe;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_ps2_host_tx
// Brief   : Self-checking bench with a PS/2 device model and frame reference.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

  localparam int INH  = 100;
  localparam int TMO  = 2000;
  localparam int FLT  = 8;
  localparam int HALF = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       glitch = 1'b0;
  logic       ps2c_oe, ps2d_oe, busy, done, err;
  logic       w_ps2c_in, w_ps2d_in;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int clow_cnt = 0;

  // Open-drain bus: either side may pull a line low.
  assign w_ps2c_in = ~ps2c_oe & dev_clk & ~glitch;
  assign w_ps2d_in = ~ps2d_oe & dev_data;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN    (FLT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_start(tx_start),
    .ps2c_in (w_ps2c_in),
    .ps2d_in (w_ps2d_in),
    .ps2c_oe (ps2c_oe),
    .ps2d_oe (ps2d_oe),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done)    done_cnt++;
    if (err)     err_cnt++;
    if (ps2c_oe) clow_cnt++;
  end

  // Reference: frame bit n (0..9) as seen on the wire = data LSB first, odd parity, stop.
  function automatic logic [9:0] expected_frame(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += b[i];
    return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b};
  endfunction

  task automatic pulse_start(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic wait_idle(output bit idle);
    idle = 1'b0;
    for (int i = 0; i < 600 && !idle; i++) begin
      @(negedge clk);
      if (!busy) idle = 1'b1;
    end
    repeat (3) @(negedge clk);
  endtask

  // Device: waits for request-to-send, clocks 11 pulses, samples bits on rises.
  task automatic device_frame(input bit do_ack, input bit glitchy, input int stop_after,
                              output logic [9:0] bits, output bit got_req, output bit start_ok);
    bits = '0; got_req = 1'b0; start_ok = 1'b0;
    for (int i = 0; i < INH + 400 && !got_req; i++) begin
      @(negedge clk);
      if (!ps2c_oe && ps2d_oe) got_req = 1'b1;
    end
    if (!got_req) return;
    repeat (HALF) @(negedge clk);
    start_ok = (w_ps2d_in == 1'b0);
    for (int n = 1; n <= 11; n++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      if (n == stop_after) return;
      dev_clk = 1'b1;
      if (n <= 10) bits[n-1] = w_ps2d_in;
      if (n == 10 && do_ack) dev_data = 1'b0;
      if (glitchy && n >= 2 && n <= 7) begin
        repeat (10) @(negedge clk);
        glitch = 1'b1;
        repeat (3) @(negedge clk);
        glitch = 1'b0;
        repeat (HALF - 13) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
    dev_data = 1'b1;
  endtask

  task automatic test_reset;
    int c0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ps2c_oe, ps2d_oe, busy, done, err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 00000", {ps2c_oe, ps2d_oe, busy, done, err});
    end
    rst = 1'b1;
    c0 = clow_cnt;
    repeat (50) @(negedge clk);
    n_checks++;
    if (clow_cnt - c0 != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_quiet: clow=%0d busy=%b expected 0 0", clow_cnt - c0, busy);
    end
  endtask

  task automatic test_frame(input string name, input logic [7:0] b, input bit glitchy);
    logic [9:0] bits, exp;
    bit got_req, start_ok, idle;
    int d0, e0, c0;
    exp = expected_frame(b);
    d0 = done_cnt; e0 = err_cnt; c0 = clow_cnt;
    pulse_start(b);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL %s busy_rise: got %b expected 1", name, busy);
    end
    device_frame(1'b1, glitchy, 0, bits, got_req, start_ok);
    wait_idle(idle);
    n_checks++;
    if (!got_req || !idle) begin
      n_fail++; $display("FAIL %s handshake: req=%b idle=%b expected 1 1", name, got_req, idle);
    end
    n_checks++;
    if (start_ok !== 1'b1) begin
      n_fail++; $display("FAIL %s start_bit: got %b expected 1", name, start_ok);
    end
    n_checks++;
    if (bits !== exp) begin
      n_fail++; $display("FAIL %s frame_bits: got %b expected %b", name, bits, exp);
    end
    n_checks++;
    if (clow_cnt - c0 != INH + 1) begin
      n_fail++; $display("FAIL %s inhibit_len: got %0d expected %0d", name, clow_cnt - c0, INH + 1);
    end
    n_checks++;
    if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
      n_fail++; $display("FAIL %s done_err: got %0d/%0d expected 1/0", name, done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_no_ack;
    logic [9:0] bits;
    bit got_req, start_ok, idle;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    pulse_start(8'h00);
    device_frame(1'b0, 1'b0, 0, bits, got_req, start_ok);
    wait_idle(idle);
    n_checks++;
    if (bits !== expected_frame(8'h00) || bits[8] !== 1'b1) begin
      n_fail++; $display("FAIL no_ack_bits: got %b expected %b", bits, expected_frame(8'h00));
    end
    n_checks++;
    if (err_cnt - e0 != 1 || done_cnt - d0 != 0 || !idle) begin
      n_fail++;
      $display("FAIL no_ack_result: err=%0d done=%0d idle=%b expected 1 0 1", err_cnt - e0, done_cnt - d0, idle);
    end
  endtask

  task automatic test_timeout;
    int lat, d0, e0;
    bit seen_low, seen_rel, seen_err;
    d0 = done_cnt; e0 = err_cnt;
    seen_low = 0; seen_rel = 0; seen_err = 0; lat = 0;
    pulse_start(8'h5A);
    for (int i = 0; i < INH + 20 && !seen_rel; i++) begin
      @(negedge clk);
      if (ps2c_oe) seen_low = 1;
      else if (seen_low) seen_rel = 1;
    end
    for (int i = 0; i < TMO + 50 && !seen_err; i++) begin
      @(negedge clk);
      lat++;
      if (err) seen_err = 1;
    end
    n_checks++;
    if (!seen_rel || !seen_err || lat < TMO - 2 || lat > TMO + 2) begin
      n_fail++;
      $display("FAIL timeout_latency: got %0d (err seen %b) expected %0d..%0d", lat, seen_err, TMO - 2, TMO + 2);
    end
    n_checks++;
    if ({ps2c_oe, ps2d_oe} !== 2'b00) begin
      n_fail++; $display("FAIL timeout_oe: got %b expected 00", {ps2c_oe, ps2d_oe});
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
      n_fail++;
      $display("FAIL timeout_result: busy=%b err=%0d done=%0d expected 0 1 0", busy, err_cnt - e0, done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] bits;
    logic [7:0] first;
    bit got_req, start_ok, idle;
    int d0, c0;
    first = 8'($urandom);
    if (first == 8'hF4) first = 8'h4F;
    d0 = done_cnt;
    pulse_start(first);
    repeat (10) @(negedge clk);
    pulse_start(8'hF4);
    device_frame(1'b1, 1'b0, 0, bits, got_req, start_ok);
    wait_idle(idle);
    n_checks++;
    if (bits !== expected_frame(first)) begin
      n_fail++; $display("FAIL b2b_bits: got %b expected %b", bits, expected_frame(first));
    end
    c0 = clow_cnt;
    repeat (INH + 50) @(negedge clk);
    n_checks++;
    if (done_cnt - d0 != 1 || clow_cnt - c0 != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_single: done=%0d clow=%0d busy=%b expected 1 0 0", done_cnt - d0, clow_cnt - c0, busy);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [9:0] bits;
    bit got_req, start_ok;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    pulse_start(8'hED);
    device_frame(1'b1, 1'b0, 5, bits, got_req, start_ok);
    n_checks++;
    if (ps2d_oe !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_bit4: ps2d_oe=%b busy=%b expected 1 1", ps2d_oe, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({ps2c_oe, ps2d_oe, busy} !== 3'b000) begin
      n_fail++; $display("FAIL mid_reset: got %b expected 000", {ps2c_oe, ps2d_oe, busy});
    end
    dev_clk = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++;
    if (done_cnt - d0 != 0 || err_cnt - e0 != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_after: done=%0d err=%0d busy=%b expected 0 0 0", done_cnt - d0, err_cnt - e0, busy);
    end
    test_frame("post_reset", 8'hED, 1'b0);
  endtask

  initial begin
    test_reset();
    test_frame("ed", 8'hED, 1'b0);
    for (int k = 0; k < 3; k++) test_frame("random", 8'($urandom), 1'b0);
    test_no_ack();
    test_timeout();
    test_back_to_back();
    test_reset_mid_frame();
    test_frame("glitch", 8'($urandom), 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
